// File: rtl/mc_instr_fill.sv
// mc_instr_fill: instruction-cache line-fill responder on the memory-controller side.
// It takes a CPU fetch miss, reads the 16 words of the containing line one at a time
// from word-wide instruction memory, and returns the assembled 512-bit line with a
// one-cycle valid pulse.
//
// Ports:
//   clk, rst        - clock (rising edge) and asynchronous active-high reset
//   cacheMissFetch  - fill request (level), sampled only in IDLE
//   instrAddr       - word address of the missing instruction
//   mcInstrValid    - one-cycle pulse: mcInstrIn holds a complete line
//   mcInstrIn       - filled line, word k at bits [32k+31:32k]
//   busy            - high in every state except IDLE
//   memRdEn/memAddr - one-cycle word read strobe and its word address
//   memRdData       - read data, qualified by memRdValid
//   memRdValid      - read response, honoured only in WAIT
//
// Build option: define IFILL_CRITICAL_FIRST_EN to fetch the missing word first
// and wrap around the line; otherwise words are fetched in order 0..15.
module mc_instr_fill #(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cacheMissFetch,
  input  logic [ADDR_W-1:0]        instrAddr,
  output logic                     mcInstrValid,
  output logic [LINE_WORDS*32-1:0] mcInstrIn,
  output logic                     busy,
  output logic                     memRdEn,
  output logic [ADDR_W-1:0]        memAddr,
  input  logic [31:0]              memRdData,
  input  logic                     memRdValid
);

  if (LINE_WORDS != 16) begin : gLineWordsCheck
    $error("mc_instr_fill: LINE_WORDS must be 16");
  end

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StDrain
  } stateE;

  stateE                   stateQ, stateD;
  logic [ADDR_W-1:0]       baseQ, baseD;
  logic [3:0]              cntQ, cntD;
  logic [3:0]              startQ, startD;
  logic [LINE_WORDS*32-1:0] lineQ;
  logic [3:0]              idx;
  logic [3:0]              reqStart;
  logic                    laneWe;

`ifdef IFILL_CRITICAL_FIRST_EN
  assign reqStart = instrAddr[3:0];
`else
  logic unusedLowAddr;
  assign unusedLowAddr = ^instrAddr[3:0];
  assign reqStart      = 4'd0;
`endif

  // 4-bit add wraps naturally, giving the critical-first rotation.
  assign idx = startQ + cntQ;

  always_comb begin
    stateD = stateQ;
    baseD  = baseQ;
    cntD   = cntQ;
    startD = startQ;
    laneWe = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (cacheMissFetch) begin
          baseD  = {instrAddr[ADDR_W-1:4], 4'b0000};
          cntD   = 4'd0;
          startD = reqStart;
          stateD = StIssue;
        end
      end
      StIssue: stateD = StWait;
      StWait: begin
        if (memRdValid) begin
          laneWe = 1'b1;
          if (cntQ == 4'd15) begin
            stateD = StDone;
          end else begin
            cntD   = cntQ + 4'd1;
            stateD = StIssue;
          end
        end
      end
      StDone:  stateD = StDrain;
      // Request is ignored here so a CPU that drops it one cycle late gets no refill.
      StDrain: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
      baseQ  <= '0;
      cntQ   <= 4'd0;
      startQ <= 4'd0;
    end else begin
      stateQ <= stateD;
      baseQ  <= baseD;
      cntQ   <= cntD;
      startQ <= startD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lineQ <= '0;
    end else if (laneWe) begin
      lineQ[{idx, 5'b00000} +: 32] <= memRdData;
    end
  end

  // Line alignment keeps the low nibble of base at zero, so no carry leaves bit 3.
  assign memAddr      = baseQ + {{(ADDR_W-4){1'b0}}, idx};
  assign memRdEn      = (stateQ == StIssue);
  assign mcInstrValid = (stateQ == StDone);
  assign busy         = (stateQ != StIdle);
  assign mcInstrIn    = lineQ;

endmodule

// File: tb/tb_mc_instr_fill.sv
// Self-checking bench for mc_instr_fill. A memory responder with configurable wait
// states serves reads from mem[a] = a ^ 32'hA5A50000; expected read addresses and
// lines are queued when a request is driven and compared when the DUT produces them.
// Honours IFILL_CRITICAL_FIRST_EN for the expected fetch order.
module tb_mc_instr_fill;

  logic         clk = 1'b0;
  logic         rst;
  logic         cacheMissFetch;
  logic [31:0]  instrAddr;
  logic         mcInstrValid;
  logic [511:0] mcInstrIn;
  logic         busy;
  logic         memRdEn;
  logic [31:0]  memAddr;
  logic [31:0]  memRdData;
  logic         memRdValid;

  mc_instr_fill #(.LINE_WORDS(16), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .cacheMissFetch(cacheMissFetch),
    .instrAddr     (instrAddr),
    .mcInstrValid  (mcInstrValid),
    .mcInstrIn     (mcInstrIn),
    .busy          (busy),
    .memRdEn       (memRdEn),
    .memAddr       (memAddr),
    .memRdData     (memRdData),
    .memRdValid    (memRdValid)
  );

  always #5 clk = ~clk;

`ifdef IFILL_CRITICAL_FIRST_EN
  localparam bit Cf = 1'b1;
`else
  localparam bit Cf = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0]  addrQ[$];
  logic [511:0] lineQ[$];
  logic [511:0] lastExpLine = '0;

  int          cyc = 0;
  int          reqCyc = 0;
  int          validCyc = 0;
  int          validCount = 0;
  int          rdEnCount = 0;
  int          fillIssued = 0;
  logic [31:0] firstAddr = '0;
  int          waitMode = 0;
  int          extraSum = 0;
  int          pendCnt = 0;
  logic [31:0] pendAddr = '0;
  bit          strayIdle = 1'b0;
  bit          strayIssue = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  function automatic logic [511:0] expLine(input logic [31:0] a);
    logic [511:0] l;
    logic [31:0]  b;
    b = {a[31:4], 4'b0000};
    for (int k = 0; k < 16; k++) l[32*k +: 32] = memWord(b + k);
    return l;
  endfunction

  // Memory responder plus output monitor; acts at posedge+1.
  initial begin
    int extra;
    memRdValid = 1'b0;
    memRdData  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      memRdValid = 1'b0;
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          memRdValid = 1'b1;
          memRdData  = memWord(pendAddr);
        end
      end
      if (strayIdle && !busy && !memRdValid) begin
        memRdValid = 1'b1;
        memRdData  = 32'hDEADBEEF;
        strayIdle  = 1'b0;
      end
      if (memRdEn) begin
        rdEnCount++;
        check("one outstanding read", pendCnt, 0);
        if (fillIssued == 0) firstAddr = memAddr;
        fillIssued++;
        if (addrQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected memRdEn: got addr %0h expected no read", memAddr);
        end else begin
          check("memAddr", memAddr, addrQ.pop_front());
        end
        extra = (waitMode == 5) ? int'($urandom_range(0, 4)) : waitMode;
        extraSum += extra;
        pendAddr = memAddr;
        pendCnt  = 1 + extra;
        if (strayIssue) begin
          memRdValid = 1'b1;
          memRdData  = 32'h0BAD0BAD;
          strayIssue = 1'b0;
        end
      end
      if (mcInstrValid) begin
        validCount++;
        validCyc = cyc;
        if (lineQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected mcInstrValid: got 1 expected 0");
        end else begin
          check("line", mcInstrIn, lineQ.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pushExpect(input logic [31:0] a);
    logic [3:0] s;
    s = Cf ? a[3:0] : 4'd0;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] w;
      w = s + 4'(k);
      addrQ.push_back({a[31:4], w});
    end
    lastExpLine = expLine(a);
    lineQ.push_back(lastExpLine);
  endtask

  task automatic startReq(input logic [31:0] a);
    extraSum       = 0;
    fillIssued     = 0;
    instrAddr      = a;
    cacheMissFetch = 1'b1;
    reqCyc         = cyc + 1;
  endtask

  task automatic waitValid(output int lat);
    int startCount;
    int i;
    startCount = validCount;
    i = 0;
    while (validCount == startCount && i < 2000) begin
      tick(1);
      i++;
    end
    if (validCount == startCount) begin
      checks++;
      errors++;
      $display("FAIL fill timeout: got no mcInstrValid expected one within 2000 cycles");
    end
    lat = validCyc - reqCyc + 1;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          mode;
    logic [31:0] first;
    logic [31:0] lane0;
    logic [31:0] lane13;
    logic [31:0] lane15;
    int          lat;
  } vecT;

  vecT vecs[5];

  initial begin
    int lat;
    int rc;
    int vc;

    vecs[0] = '{32'h0000_0043, 0, Cf ? 32'h43 : 32'h40, 32'hA5A50040, 32'hA5A5004D,
                32'hA5A5004F, 33};
    vecs[1] = '{32'h0000_004D, 0, Cf ? 32'h4D : 32'h40, 32'hA5A50040, 32'hA5A5004D,
                32'hA5A5004F, 33};
    vecs[2] = '{32'h1234_5670, 1, 32'h1234_5670, 32'hB791_5670, 32'hB791_567D,
                32'hB791_567F, 49};
    vecs[3] = '{32'hFFFF_FFF8, 2, Cf ? 32'hFFFF_FFF8 : 32'hFFFF_FFF0, 32'h5A5A_FFF0,
                32'h5A5A_FFFD, 32'h5A5A_FFFF, 65};
    vecs[4] = '{32'h0000_0000, 0, 32'h0000_0000, 32'hA5A50000, 32'hA5A5000D,
                32'hA5A5000F, 33};

    rst            = 1'b1;
    cacheMissFetch = 1'b0;
    instrAddr      = '0;
    #1;
    check("reset mcInstrValid", mcInstrValid, 0);
    check("reset mcInstrIn", mcInstrIn, 0);
    check("reset busy", busy, 0);
    check("reset memRdEn", memRdEn, 0);
    check("reset memAddr", memAddr, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("idle busy", busy, 0);

    // Table-driven fills.
    for (int v = 0; v < 5; v++) begin
      tick(3);
      waitMode = vecs[v].mode;
      pushExpect(vecs[v].addr);
      startReq(vecs[v].addr);
      waitValid(lat);
      check("latency", lat, vecs[v].lat);
      check("first memAddr", firstAddr, vecs[v].first);
      check("reads per fill", fillIssued, 16);
      check("lane0", mcInstrIn[31:0], vecs[v].lane0);
      check("lane13", mcInstrIn[447:416], vecs[v].lane13);
      check("lane15", mcInstrIn[511:480], vecs[v].lane15);
      cacheMissFetch = 1'b0;
    end

    // Random wait states.
    tick(3);
    waitMode = 5;
    pushExpect(32'h0000_0043);
    startReq(32'h0000_0043);
    waitValid(lat);
    cacheMissFetch = 1'b0;
    check("random-wait latency", lat, 33 + extraSum);
    check("random-wait reads", fillIssued, 16);
    waitMode = 0;

    // Request held through DRAIN: no refill.
    tick(3);
    pushExpect(32'h0000_0043);
    startReq(32'h0000_0043);
    waitValid(lat);
    check("held latency", lat, 33);
    tick(2);
    cacheMissFetch = 1'b0;
    rc = rdEnCount;
    vc = validCount;
    tick(6);
    check("held busy", busy, 0);
    check("held no reads", rdEnCount, rc);
    check("held no valid", validCount, vc);

    // Request held into IDLE: exactly one refill.
    pushExpect(32'h0000_0043);
    startReq(32'h0000_0043);
    waitValid(lat);
    vc = validCount;
    pushExpect(32'h0000_0043);
    tick(3);
    cacheMissFetch = 1'b0;
    waitValid(lat);
    tick(40);
    check("refill count", validCount, vc + 1);
    check("refill addr queue", addrQ.size(), 0);
    check("refill busy", busy, 0);

    // Reset mid-fill with an outstanding response.
    waitMode = 3;
    pushExpect(32'h0000_0080);
    startReq(32'h0000_0080);
    rc = 0;
    while (fillIssued < 9 && rc < 500) begin
      tick(1);
      rc++;
    end
    check("reached word 8", fillIssued, 9);
    rst = 1'b1;
    cacheMissFetch = 1'b0;
    #1;
    check("midrst mcInstrValid", mcInstrValid, 0);
    check("midrst mcInstrIn", mcInstrIn, 0);
    check("midrst busy", busy, 0);
    check("midrst memRdEn", memRdEn, 0);
    check("midrst memAddr", memAddr, 0);
    addrQ.delete();
    lineQ.delete();
    lastExpLine = '0;
    waitMode = 0;
    tick(2);
    rst = 1'b0;
    vc = validCount;
    tick(6);
    strayIdle = 1'b1;
    tick(4);
    check("post-rst line", mcInstrIn, lastExpLine);
    check("post-rst busy", busy, 0);
    check("post-rst no valid", validCount, vc);
    pushExpect(32'h0000_0080);
    startReq(32'h0000_0080);
    waitValid(lat);
    cacheMissFetch = 1'b0;
    check("post-rst latency", lat, 33);
    check("post-rst first memAddr", firstAddr, 32'h0000_0080);

    // Spurious responses in IDLE and ISSUE.
    tick(3);
    strayIdle = 1'b1;
    tick(4);
    check("idle stray line", mcInstrIn, lastExpLine);
    check("idle stray busy", busy, 0);
    strayIssue = 1'b1;
    pushExpect(32'h0000_00C5);
    startReq(32'h0000_00C5);
    waitValid(lat);
    cacheMissFetch = 1'b0;
    check("issue stray latency", lat, 33);
    check("issue stray reads", fillIssued, 16);
    tick(4);
    check("final busy", busy, 0);
    check("final addr queue", addrQ.size(), 0);
    check("final line queue", lineQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
